// File: rtl/spi_target_receiver.sv
// SPI mode-0 target: oversamples spiClk/cs/mosi in the sysClk domain, assembles MSB-first words
// into a first-word-fall-through RX FIFO, and echoes RESP_INIT followed by each received word on miso.
module spi_target_receiver #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 4,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] RESP_INIT   = 8'hA5
) (
  input  logic                      sysClk,
  input  logic                      reset,
  input  logic                      spiClk,
  input  logic                      cs,
  input  logic                      mosi,
  output logic                      miso,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  input  logic                      rx_rd,
  output logic [$clog2(DEPTH):0]    rx_count,
  output logic                      overflow,
  output logic                      frame_active,
  output logic                      frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  // cs synchronizer resets to 0 so a cs already held low at reset release is not seen as a fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  state_e                state_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, echo_q;
  logic                  load_pending_q, miso_q, frame_done_q;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  byte_done;

  assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  // A cs rise in the same cycle as the last spiClk rise ends the frame without a push.
  assign byte_done = (state_q == ACTIVE) && !cs_rise && sclk_rise && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= RESP_INIT;
      echo_q         <= '0;
      load_pending_q <= 1'b0;
      miso_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q        <= ACTIVE;
            bit_cnt_q      <= '0;
            tx_shift_q     <= RESP_INIT;
            load_pending_q <= 1'b0;
          end
        end
        ACTIVE: begin
          miso_q <= tx_shift_q[DATA_WIDTH-1];
          if (cs_rise) begin
            state_q        <= IDLE;
            frame_done_q   <= 1'b1;
            bit_cnt_q      <= '0;
            load_pending_q <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_word;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q      <= '0;
                echo_q         <= rx_word;
                load_pending_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            // The echo load replaces the shift on the fall that follows a completed word.
            if (sclk_fall) begin
              if (load_pending_q) begin
                tx_shift_q     <= echo_q;
                load_pending_q <= 1'b0;
              end else begin
                tx_shift_q <= tx_shift_q << 1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso         = miso_q;
  assign frame_done   = frame_done_q;
  assign frame_active = (state_q == ACTIVE);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q;
  logic                  pop, full, push_ok;

  assign pop     = rx_rd && (count_q != '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = byte_done && (!full || pop);

  // NOTE: storage has no reset; only pointers and count need defined values.
  always_ff @(posedge sysClk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_word;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (byte_done && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;
  assign overflow = overflow_q;

endmodule
